conv_window_buffer: RTL and testbench

Parametrised, multi-tap successor to the single-port CNN activation buffer. It stores signed activations and operates in one of two modes:
- BUF_RANDOM: explicitly addressed writes and reads, as in the original buffer.
- BUF_RING: auto-incrementing circular line buffer. NUM_RD taps read relative to the newest sample, feeding convolution windows directly.
It sits between the input loader and the PE array and provides NUM_RD registered reads per cycle.

---
 rtl/cnn_buf_pkg.sv | 16 +
 rtl/conv_window_buffer_ring_ptr.sv | 53 +++++
 rtl/conv_window_buffer.sv | 99 +++++++++
 tb/tb_conv_window_buffer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_buf_pkg.sv
// Shared types and default sizes for the CNN activation buffer family.
// Both the ring pointer sub-module and the window buffer top import this package.
package cnn_buf_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_NUM_RD = 3;

  typedef enum logic {
    BUF_RANDOM = 1'b0,
    BUF_RING   = 1'b1
  } buf_mode_e;

  typedef logic signed [DEF_DATA_W-1:0] act_t;

endpackage : cnn_buf_pkg

// File: rtl/conv_window_buffer_ring_ptr.sv
// Ring write pointer, saturating fill count and mode-change detection.
// base_ptr is the pre-edge pointer used for both ring writes and tap addressing.
module ring_ptr
  import cnn_buf_pkg::*;
#(
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  buf_mode_e         mode,
  input  logic              wr_en,
  output logic [ADDR_W-1:0] base_ptr,
  output logic [ADDR_W:0]   fill_count,
  output logic              full,
  output logic              mode_chg,
  output logic              wr_accept
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  buf_mode_e mode_q;

  assign mode_chg  = (mode != mode_q);
  // A write coinciding with clr or a mode switch is discarded.
  assign wr_accept = wr_en && !clr && !mode_chg;
  assign full      = (fill_count == FULL_CNT);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_ptr   <= '0;
      fill_count <= '0;
      mode_q     <= BUF_RANDOM;
    end else if (clr) begin
      base_ptr   <= '0;
      fill_count <= '0;
      mode_q     <= mode;
    end else begin
      mode_q <= mode;
      if (mode_chg) begin
        base_ptr   <= '0;
        fill_count <= '0;
      end else if (wr_accept && mode == BUF_RING) begin
        base_ptr <= base_ptr + ADDR_W'(1);
        if (!full) fill_count <= fill_count + (ADDR_W + 1)'(1);
      end
    end
  end

endmodule : ring_ptr

// File: rtl/conv_window_buffer.sv
// Multi-tap activation buffer: random-access or circular line buffer feeding
// NUM_RD registered convolution taps per cycle.
module conv_window_buffer
  import cnn_buf_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int NUM_RD = DEF_NUM_RD,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              mode,
  input  logic                              clr,
  input  logic                              wr_en,
  input  logic [ADDR_W-1:0]                 wr_addr,
  input  logic signed [DATA_W-1:0]          wr_data,
  input  logic                              rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]          rd_addr,
  output logic signed [NUM_RD*DATA_W-1:0]   rd_data,
  output logic                              rd_valid,
  output logic [ADDR_W:0]                   fill_count,
  output logic                              full,
  output logic [ADDR_W-1:0]                 wr_ptr
);

  buf_mode_e                mode_e;
  logic [ADDR_W-1:0]        base_ptr;
  logic                     mode_chg;
  logic                     wr_accept;
  logic signed [DATA_W-1:0] mem      [DEPTH];
  logic [ADDR_W-1:0]        lane_off [NUM_RD];
  logic [ADDR_W-1:0]        lane_phy [NUM_RD];
  logic signed [DATA_W-1:0] lane_val [NUM_RD];

  assign mode_e = buf_mode_e'(mode);
  assign wr_ptr = base_ptr;

  ring_ptr #(.DEPTH(DEPTH)) u_ring_ptr (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .mode       (mode_e),
    .wr_en      (wr_en),
    .base_ptr   (base_ptr),
    .fill_count (fill_count),
    .full       (full),
    .mode_chg   (mode_chg),
    .wr_accept  (wr_accept)
  );

  // NOTE: storage is reset explicitly because stale samples must read as zero
  // after reset or clr; this rules out a plain RAM macro for this buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_accept) begin
      if (mode_e == BUF_RING) mem[base_ptr] <= wr_data;
      else                    mem[wr_addr]  <= wr_data;
    end
  end

  // Ring taps are read-first against the pre-edge pointer; random taps are
  // write-first so a colliding lane sees the incoming sample.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      lane_off[i] = rd_addr[i*ADDR_W +: ADDR_W];
      lane_phy[i] = '0;
      lane_val[i] = '0;
      if (mode_e == BUF_RING) begin
        lane_phy[i] = base_ptr - ADDR_W'(1) - lane_off[i];
        if ({1'b0, lane_off[i]} < fill_count) lane_val[i] = mem[lane_phy[i]];
      end else begin
        lane_phy[i] = lane_off[i];
        if (wr_accept && wr_addr == lane_off[i]) lane_val[i] = wr_data;
        else                                     lane_val[i] = mem[lane_phy[i]];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (clr) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        for (int i = 0; i < NUM_RD; i++) rd_data[i*DATA_W +: DATA_W] <= lane_val[i];
      end
    end
  end

endmodule : conv_window_buffer

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer: random mode, collisions, ring fill,
// wrap, masking, read-first ordering and asynchronous reset.
module tb_conv_window_buffer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int NUM_RD = 3;
  localparam int ADDR_W = 4;

  logic                            clk = 1'b0;
  logic                            reset;
  logic                            mode;
  logic                            clr;
  logic                            wr_en;
  logic [ADDR_W-1:0]               wr_addr;
  logic signed [DATA_W-1:0]        wr_data;
  logic                            rd_en;
  logic [NUM_RD*ADDR_W-1:0]        rd_addr;
  logic signed [NUM_RD*DATA_W-1:0] rd_data;
  logic                            rd_valid;
  logic [ADDR_W:0]                 fill_count;
  logic                            full;
  logic [ADDR_W-1:0]               wr_ptr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  conv_window_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .clr        (clr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fill_count (fill_count),
    .full       (full),
    .wr_ptr     (wr_ptr)
  );

  function automatic logic [DATA_W-1:0] lane(input int i);
    return rd_data[i*DATA_W +: DATA_W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, a1, a2);
    rd_addr = {a2, a1, a0};
  endtask

  task automatic test_reset();
    reset = 1'b0; mode = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; rd_en = 1'b0; rd_addr = '0;
    #12 reset = 1'b1;
    tick();
    tests++;
    if (rd_data !== '0 || rd_valid !== 1'b0) begin
      fails++; $display("FAIL reset_rd: data=%h valid=%b exp 000000/0", rd_data, rd_valid);
    end
    tests++;
    if (fill_count !== '0 || full !== 1'b0 || wr_ptr !== '0) begin
      fails++; $display("FAIL reset_ptr: fill=%0d full=%b ptr=%0d exp 0/0/0", fill_count, full, wr_ptr);
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] exp;
    mode = 1'b0; wr_en = 1'b1; rd_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wr_addr = ADDR_W'(k + 1);
      wr_data = DATA_W'(k + 2);
      set_rd(ADDR_W'(k), '0, '0);
      tick();
      exp = (k == 0) ? 8'd0 : DATA_W'(k + 1);
      tests++;
      if (rd_valid !== 1'b1 || lane(0) !== exp) begin
        fails++; $display("FAIL rnd_read%0d: lane0=%0d valid=%b exp %0d/1", k, lane(0), rd_valid, exp);
      end
    end
  endtask

  task automatic test_collision();
    wr_en = 1'b1; wr_addr = 4'd8; wr_data = 8'sd19; rd_en = 1'b1;
    set_rd(4'd8, 4'd1, 4'd4);
    tick();
    tests++;
    if (lane(0) !== 8'd19 || lane(1) !== 8'd2 || lane(2) !== 8'd5) begin
      fails++; $display("FAIL rnd_collide: lanes=%0d,%0d,%0d exp 19,2,5", lane(0), lane(1), lane(2));
    end
    wr_en = 1'b0; rd_en = 1'b0; set_rd(4'd0, 4'd0, 4'd0);
    tick();
    tests++;
    if (rd_valid !== 1'b0 || lane(0) !== 8'd19 || fill_count !== '0) begin
      fails++; $display("FAIL rnd_hold: valid=%b lane0=%0d fill=%0d exp 0/19/0", rd_valid, lane(0), fill_count);
    end
  endtask

  task automatic test_ring_wrap();
    mode = 1'b1; wr_en = 1'b1; wr_data = 8'sd99; rd_en = 1'b0;
    tick();
    tests++;
    if (fill_count !== '0 || wr_ptr !== '0) begin
      fails++; $display("FAIL mode_chg_drop: fill=%0d ptr=%0d exp 0/0", fill_count, wr_ptr);
    end
    for (int v = 1; v <= 20; v++) begin
      wr_data = DATA_W'(v);
      tick();
    end
    wr_en = 1'b0;
    tests++;
    if (wr_ptr !== 4'd4 || fill_count !== 5'd16 || full !== 1'b1) begin
      fails++; $display("FAIL ring_full: ptr=%0d fill=%0d full=%b exp 4/16/1", wr_ptr, fill_count, full);
    end
    rd_en = 1'b1; set_rd(4'd0, 4'd1, 4'd2);
    tick();
    tests++;
    if (lane(0) !== 8'd20 || lane(1) !== 8'd19 || lane(2) !== 8'd18) begin
      fails++; $display("FAIL ring_newest: lanes=%0d,%0d,%0d exp 20,19,18", lane(0), lane(1), lane(2));
    end
    set_rd(4'd15, 4'd15, 4'd0);
    tick();
    tests++;
    if (lane(0) !== 8'd5 || lane(1) !== 8'd5 || lane(2) !== 8'd20) begin
      fails++; $display("FAIL ring_oldest: lanes=%0d,%0d,%0d exp 5,5,20", lane(0), lane(1), lane(2));
    end
  endtask

  task automatic test_ring_mask();
    clr = 1'b1; wr_en = 1'b1; wr_data = 8'sd55; rd_en = 1'b1;
    tick();
    clr = 1'b0;
    tests++;
    if (fill_count !== '0 || wr_ptr !== '0 || rd_valid !== 1'b0 || rd_data !== '0) begin
      fails++; $display("FAIL clr: fill=%0d ptr=%0d valid=%b data=%h exp 0/0/0/000000", fill_count, wr_ptr, rd_valid, rd_data);
    end
    rd_en = 1'b0;
    wr_data = 8'sd7; tick();
    wr_data = 8'sd8; tick();
    wr_en = 1'b0;
    tests++;
    if (fill_count !== 5'd2 || wr_ptr !== 4'd2 || full !== 1'b0) begin
      fails++; $display("FAIL mask_fill: fill=%0d ptr=%0d full=%b exp 2/2/0", fill_count, wr_ptr, full);
    end
    rd_en = 1'b1; set_rd(4'd0, 4'd1, 4'd2);
    tick();
    tests++;
    if (lane(0) !== 8'd8 || lane(1) !== 8'd7 || lane(2) !== 8'd0) begin
      fails++; $display("FAIL mask_read: lanes=%0d,%0d,%0d exp 8,7,0", lane(0), lane(1), lane(2));
    end
  endtask

  task automatic test_read_first();
    wr_en = 1'b1; wr_data = 8'sd9; rd_en = 1'b1; set_rd(4'd0, 4'd1, 4'd2);
    tick();
    tests++;
    if (lane(0) !== 8'd8 || lane(1) !== 8'd7 || lane(2) !== 8'd0) begin
      fails++; $display("FAIL read_first: lanes=%0d,%0d,%0d exp 8,7,0", lane(0), lane(1), lane(2));
    end
    wr_en = 1'b0;
    tick();
    tests++;
    if (lane(0) !== 8'd9 || lane(1) !== 8'd8 || lane(2) !== 8'd7 || fill_count !== 5'd3) begin
      fails++; $display("FAIL read_after: lanes=%0d,%0d,%0d fill=%0d exp 9,8,7/3", lane(0), lane(1), lane(2), fill_count);
    end
  endtask

  task automatic test_async_reset();
    wr_en = 1'b1; rd_en = 1'b1; set_rd(4'd0, 4'd0, 4'd0);
    wr_data = 8'sd10; tick();
    wr_data = 8'sd11; tick();
    tests++;
    if (rd_valid !== 1'b1 || lane(0) !== 8'd10) begin
      fails++; $display("FAIL burst_pre: valid=%b lane0=%0d exp 1/10", rd_valid, lane(0));
    end
    #3 reset = 1'b0;
    #1;
    tests++;
    if (rd_data !== '0 || rd_valid !== 1'b0) begin
      fails++; $display("FAIL async_rd: data=%h valid=%b exp 000000/0", rd_data, rd_valid);
    end
    tests++;
    if (fill_count !== '0 || wr_ptr !== '0 || full !== 1'b0) begin
      fails++; $display("FAIL async_ptr: fill=%0d ptr=%0d full=%b exp 0/0/0", fill_count, wr_ptr, full);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    #2 reset = 1'b1;
    tick();
    rd_en = 1'b1; set_rd(4'd0, 4'd1, 4'd15);
    tick();
    tests++;
    if (rd_valid !== 1'b1 || rd_data !== '0) begin
      fails++; $display("FAIL post_ring: valid=%b data=%h exp 1/000000", rd_valid, rd_data);
    end
    mode = 1'b0; rd_en = 1'b0;
    tick();
    rd_en = 1'b1; set_rd(4'd0, 4'd1, 4'd3);
    tick();
    tests++;
    if (rd_valid !== 1'b1 || rd_data !== '0) begin
      fails++; $display("FAIL post_storage: valid=%b data=%h exp 1/000000", rd_valid, rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_random();
    test_collision();
    test_ring_wrap();
    test_ring_mask();
    test_read_first();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_conv_window_buffer
